// File: rtl/decoder_n_pipe.sv
// Pipelined N-to-NUM_OUT decoder (one-hot or thermometer per transaction) with a
// 2-entry skid buffer between valid/ready interfaces and a saturating range-error counter.
module decoder_n_pipe #(
  parameter int SEL_W      = 2,
  parameter int NUM_OUT    = 4,
  parameter int ACTIVE_LOW = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_OUT-1:0]   out_code,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam logic [NUM_OUT-1:0]   IDLE_CODE = (ACTIVE_LOW != 0) ? {NUM_OUT{1'b1}} : {NUM_OUT{1'b0}};
  localparam logic [SEL_W:0]       NUM_OUT_L = (SEL_W+1)'(NUM_OUT);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX   = {ERR_CNT_W{1'b1}};

  occ_e                 occ_q, occ_d;
  logic [NUM_OUT-1:0]   head_code_q, head_code_d;
  logic                 head_err_q, head_err_d;
  logic [NUM_OUT-1:0]   tail_code_q, tail_code_d;
  logic                 tail_err_q, tail_err_d;
  logic                 in_ready_q, in_ready_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic [NUM_OUT-1:0]   raw_code;
  logic [NUM_OUT-1:0]   new_code;
  logic                 new_err;
  logic                 push;
  logic                 pop;

  // Decode of the incoming select; only captured into the buffer on push.
  always_comb begin
    raw_code = '0;
    new_err  = ({1'b0, in_sel} >= NUM_OUT_L);
    for (int k = 0; k < NUM_OUT; k++) begin
      if (in_mode) begin
        raw_code[k] = (in_sel >= SEL_W'(k));
      end else begin
        raw_code[k] = (in_sel == SEL_W'(k));
      end
    end
    if (new_err) begin
      raw_code = '0;
    end
    new_code = (ACTIVE_LOW != 0) ? ~raw_code : raw_code;
  end

  assign out_valid = (occ_q != OCC_EMPTY);
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  // The head entry always holds what out_* shows, including the idle level when empty.
  always_comb begin
    occ_d       = occ_q;
    head_code_d = head_code_q;
    head_err_d  = head_err_q;
    tail_code_d = tail_code_q;
    tail_err_d  = tail_err_q;
    err_count_d = err_count_q;

    case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          head_code_d = new_code;
          head_err_d  = new_err;
          occ_d       = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && !pop) begin
          tail_code_d = new_code;
          tail_err_d  = new_err;
          occ_d       = OCC_TWO;
        end else if (pop && !push) begin
          head_code_d = IDLE_CODE;
          head_err_d  = 1'b0;
          occ_d       = OCC_EMPTY;
        end else if (pop && push) begin
          head_code_d = new_code;
          head_err_d  = new_err;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          head_code_d = tail_code_q;
          head_err_d  = tail_err_q;
          occ_d       = OCC_ONE;
        end
      end
      default: begin
        occ_d       = OCC_EMPTY;
        head_code_d = IDLE_CODE;
        head_err_d  = 1'b0;
      end
    endcase

    in_ready_d = (occ_d != OCC_TWO);

    if (push && new_err && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= OCC_EMPTY;
      head_code_q <= IDLE_CODE;
      head_err_q  <= 1'b0;
      tail_code_q <= IDLE_CODE;
      tail_err_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      err_count_q <= '0;
    end else begin
      occ_q       <= occ_d;
      head_code_q <= head_code_d;
      head_err_q  <= head_err_d;
      tail_code_q <= tail_code_d;
      tail_err_q  <= tail_err_d;
      in_ready_q  <= in_ready_d;
      err_count_q <= err_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_code  = head_code_q;
  assign out_err   = head_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_decoder_n_pipe.sv
// Directed testbench for decoder_n_pipe: four parameterisations driven from one
// clock/reset, each checked against hand-computed codes, flags and counter values.
module tb_decoder_n_pipe;

  logic clk;
  logic rst_n;

  // Default instance: SEL_W=2, NUM_OUT=4
  logic       dInValid, dInReady, dInMode, dOutValid, dOutReady, dOutErr;
  logic [1:0] dInSel;
  logic [3:0] dOutCode;
  logic [7:0] dErrCount;

  // Non-power-of-two instance: SEL_W=3, NUM_OUT=5
  logic       nInValid, nInReady, nInMode, nOutValid, nOutReady, nOutErr;
  logic [2:0] nInSel;
  logic [4:0] nOutCode;
  logic [7:0] nErrCount;

  // Active-low instance
  logic       aInValid, aInReady, aInMode, aOutValid, aOutReady, aOutErr;
  logic [1:0] aInSel;
  logic [3:0] aOutCode;
  logic [7:0] aErrCount;

  // Narrow error counter instance: SEL_W=3, NUM_OUT=5, ERR_CNT_W=2
  logic       sInValid, sInReady, sInMode, sOutValid, sOutReady, sOutErr;
  logic [2:0] sInSel;
  logic [4:0] sOutCode;
  logic [1:0] sErrCount;

  int checkCount = 0;
  int errorCount = 0;

  decoder_n_pipe #(.SEL_W(2), .NUM_OUT(4), .ACTIVE_LOW(0), .ERR_CNT_W(8)) uDef (
    .clk(clk), .rst_n(rst_n),
    .in_valid(dInValid), .in_ready(dInReady), .in_sel(dInSel), .in_mode(dInMode),
    .out_valid(dOutValid), .out_ready(dOutReady), .out_code(dOutCode),
    .out_err(dOutErr), .err_count(dErrCount)
  );

  decoder_n_pipe #(.SEL_W(3), .NUM_OUT(5), .ACTIVE_LOW(0), .ERR_CNT_W(8)) uN5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(nInValid), .in_ready(nInReady), .in_sel(nInSel), .in_mode(nInMode),
    .out_valid(nOutValid), .out_ready(nOutReady), .out_code(nOutCode),
    .out_err(nOutErr), .err_count(nErrCount)
  );

  decoder_n_pipe #(.SEL_W(2), .NUM_OUT(4), .ACTIVE_LOW(1), .ERR_CNT_W(8)) uAl (
    .clk(clk), .rst_n(rst_n),
    .in_valid(aInValid), .in_ready(aInReady), .in_sel(aInSel), .in_mode(aInMode),
    .out_valid(aOutValid), .out_ready(aOutReady), .out_code(aOutCode),
    .out_err(aOutErr), .err_count(aErrCount)
  );

  decoder_n_pipe #(.SEL_W(3), .NUM_OUT(5), .ACTIVE_LOW(0), .ERR_CNT_W(2)) uSat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sInValid), .in_ready(sInReady), .in_sel(sInSel), .in_mode(sInMode),
    .out_valid(sOutValid), .out_ready(sOutReady), .out_code(sOutCode),
    .out_err(sOutErr), .err_count(sErrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to 1 ns after the next rising edge, where outputs are sampled and inputs changed.
  task automatic applyStimulus;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    dInValid = 0; dInSel = '0; dInMode = 0; dOutReady = 1;
    nInValid = 0; nInSel = '0; nInMode = 0; nOutReady = 1;
    aInValid = 0; aInSel = '0; aInMode = 0; aOutReady = 1;
    sInValid = 0; sInSel = '0; sInMode = 0; sOutReady = 1;

    applyStimulus();
    applyStimulus();
    checkOutput("rst_out_valid", 32'(dOutValid), 32'd0);
    checkOutput("rst_in_ready", 32'(dInReady), 32'd1);
    checkOutput("rst_out_code", 32'(dOutCode), 32'h0);
    checkOutput("rst_out_err", 32'(dOutErr), 32'd0);
    checkOutput("rst_err_count", 32'(dErrCount), 32'd0);
    checkOutput("rst_al_code", 32'(aOutCode), 32'hF);
    #3 rst_n = 1'b1;

    // One-hot stream with out_ready held high
    applyStimulus();
    dInValid = 1; dInMode = 0;
    for (int i = 0; i < 4; i++) begin
      dInSel = 2'(i);
      applyStimulus();
      checkOutput($sformatf("onehot_code_%0d", i), 32'(dOutCode), 32'(1 << i));
      checkOutput($sformatf("onehot_valid_%0d", i), 32'(dOutValid), 32'd1);
      checkOutput($sformatf("onehot_err_%0d", i), 32'(dOutErr), 32'd0);
    end
    dInValid = 0;
    applyStimulus();
    checkOutput("onehot_drain_valid", 32'(dOutValid), 32'd0);
    checkOutput("onehot_drain_code", 32'(dOutCode), 32'h0);

    // Thermometer and range errors on NUM_OUT=5
    nInValid = 1; nInMode = 1; nInSel = 3'd2;
    applyStimulus();
    checkOutput("n5_therm2_code", 32'(nOutCode), 32'h07);
    checkOutput("n5_therm2_err", 32'(nOutErr), 32'd0);
    nInSel = 3'd6;
    applyStimulus();
    checkOutput("n5_sel6_code", 32'(nOutCode), 32'h00);
    checkOutput("n5_sel6_err", 32'(nOutErr), 32'd1);
    checkOutput("n5_sel6_count", 32'(nErrCount), 32'd1);
    nInSel = 3'd4;
    applyStimulus();
    checkOutput("n5_sel4_code", 32'(nOutCode), 32'h1F);
    checkOutput("n5_sel4_err", 32'(nOutErr), 32'd0);
    checkOutput("n5_sel4_count", 32'(nErrCount), 32'd1);
    nInSel = 3'd5; nInMode = 0;
    applyStimulus();
    checkOutput("n5_sel5_err", 32'(nOutErr), 32'd1);
    checkOutput("n5_sel5_count", 32'(nErrCount), 32'd2);
    nInValid = 0;
    applyStimulus();
    checkOutput("n5_drain_valid", 32'(nOutValid), 32'd0);
    checkOutput("n5_drain_err", 32'(nOutErr), 32'd0);

    // Backpressure: fill to two entries, extra push ignored, then drain in order
    dOutReady = 0; dInValid = 1; dInSel = 2'd1;
    applyStimulus();
    checkOutput("bp_first_code", 32'(dOutCode), 32'h2);
    checkOutput("bp_first_ready", 32'(dInReady), 32'd1);
    dInSel = 2'd2;
    applyStimulus();
    checkOutput("bp_full_ready", 32'(dInReady), 32'd0);
    checkOutput("bp_full_code", 32'(dOutCode), 32'h2);
    dInSel = 2'd3;
    applyStimulus();
    checkOutput("bp_hold_code", 32'(dOutCode), 32'h2);
    checkOutput("bp_hold_ready", 32'(dInReady), 32'd0);
    dInValid = 0; dOutReady = 1;
    applyStimulus();
    checkOutput("bp_pop1_code", 32'(dOutCode), 32'h4);
    checkOutput("bp_pop1_ready", 32'(dInReady), 32'd1);
    checkOutput("bp_pop1_valid", 32'(dOutValid), 32'd1);
    applyStimulus();
    checkOutput("bp_pop2_valid", 32'(dOutValid), 32'd0);

    // Buffered entries keep the mode they were pushed with
    dOutReady = 0; dInValid = 1; dInSel = 2'd2; dInMode = 1;
    applyStimulus();
    dInSel = 2'd1; dInMode = 0;
    applyStimulus();
    dInValid = 0; dInMode = 1; dOutReady = 1;
    checkOutput("mode_head_code", 32'(dOutCode), 32'h7);
    applyStimulus();
    checkOutput("mode_tail_code", 32'(dOutCode), 32'h2);
    applyStimulus();
    dInMode = 0;

    // Active-low polarity
    aInValid = 1; aInMode = 0; aInSel = 2'd3;
    applyStimulus();
    checkOutput("al_onehot3_code", 32'(aOutCode), 32'h7);
    aInMode = 1; aInSel = 2'd1;
    applyStimulus();
    checkOutput("al_therm1_code", 32'(aOutCode), 32'hC);
    aInValid = 0;
    applyStimulus();
    checkOutput("al_idle_code", 32'(aOutCode), 32'hF);
    checkOutput("al_idle_valid", 32'(aOutValid), 32'd0);

    // Error counter saturation at 2 bits
    sInValid = 1; sInMode = 0;
    for (int i = 0; i < 5; i++) begin
      sInSel = 3'(5 + (i % 3));
      applyStimulus();
      checkOutput($sformatf("sat_count_%0d", i), 32'(sErrCount), (i < 3) ? 32'(i + 1) : 32'd3);
      checkOutput($sformatf("sat_err_%0d", i), 32'(sOutErr), 32'd1);
    end
    sInValid = 0;
    applyStimulus();

    // Asynchronous reset with the buffer full
    dOutReady = 0; dInValid = 1; dInSel = 2'd1;
    applyStimulus();
    dInSel = 2'd2;
    applyStimulus();
    checkOutput("mid_full_ready", 32'(dInReady), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(dOutValid), 32'd0);
    checkOutput("mid_rst_code", 32'(dOutCode), 32'h0);
    checkOutput("mid_rst_ready", 32'(dInReady), 32'd1);
    checkOutput("mid_rst_n5_count", 32'(nErrCount), 32'd0);
    dInSel = 2'd0; dOutReady = 1;
    #1 rst_n = 1'b1;
    applyStimulus();
    checkOutput("post_rst_code", 32'(dOutCode), 32'h1);
    checkOutput("post_rst_valid", 32'(dOutValid), 32'd1);
    dInValid = 0;
    applyStimulus();
    checkOutput("post_rst_drain", 32'(dOutValid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
